fir_tap_sequencer: RTL and testbench



---
 rtl/fir_tap_sequencer_if.sv | 43 ++++
 rtl/fir_tap_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_sequencer_if.sv
`default_nettype none
// ============================================================================
// fir_tap_sequencer_if : sample/result handshake and MAC control bundle.
// Rev 1.0
// ============================================================================
interface fir_tap_sequencer_if #(
    parameter int ADDR_W = 3
);
    logic              inValid;
    logic              inReady;
    logic              sampWe;
    logic [ADDR_W-1:0] sampAddress;
    logic [ADDR_W-1:0] coefAddress;
    logic              accClr;
    logic              accEn;
    logic              outValid;
    logic              outReady;

    modport master (
        input  inValid,
        input  outReady,
        output inReady,
        output sampWe,
        output sampAddress,
        output coefAddress,
        output accClr,
        output accEn,
        output outValid
    );

    modport slave (
        output inValid,
        output outReady,
        input  inReady,
        input  sampWe,
        input  sampAddress,
        input  coefAddress,
        input  accClr,
        input  accEn,
        input  outValid
    );
endinterface
`default_nettype wire

// File: rtl/fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// fir_tap_sequencer : FIR control FSM (sample write, TAPS MAC cycles, drain, result).
// Optional back-to-back mode: FIR_TAP_SEQ_B2B_EN.  Rev 1.0
// ============================================================================
module fir_tap_sequencer #(
    parameter int TAPS     = 8,
    parameter int ADDR_W   = 3,
    parameter int PIPE_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    fir_tap_sequencer_if.master  seq_if
);

    localparam int                  DRAIN_W    = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_W-1:0]   LAST_TAP   = ADDR_W'(TAPS - 1);
    localparam logic [DRAIN_W-1:0]  LAST_DRAIN = DRAIN_W'(PIPE_LAT - 1);

`ifdef FIR_TAP_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_MAC   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wrPtr_q, wrPtr_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [DRAIN_W-1:0]  drain_q, drain_d;

    logic                inReady_q, inReady_d;
    logic                sampWe_q, sampWe_d;
    logic [ADDR_W-1:0]   sampAddress_q, sampAddress_d;
    logic [ADDR_W-1:0]   coefAddress_q, coefAddress_d;
    logic                accClr_q, accClr_d;
    logic                accEn_q, accEn_d;
    logic                outValid_q, outValid_d;

    // (ptr - k) mod TAPS with an explicit wrap so non-power-of-2 TAPS stays in range
    function automatic logic [ADDR_W-1:0] rd_addr(input logic [ADDR_W-1:0] ptr,
                                                  input logic [ADDR_W-1:0] k);
        logic [ADDR_W:0] sum;
        if (ptr >= k) begin
            sum = {1'b0, ptr} - {1'b0, k};
        end else begin
            sum = {1'b0, ptr} + (ADDR_W+1)'(TAPS) - {1'b0, k};
        end
        return sum[ADDR_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        wrPtr_d = wrPtr_q;
        k_d     = k_q;
        drain_d = drain_q;

        unique case (state_q)
            S_IDLE: begin
                if (seq_if.inValid && inReady_q) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                k_d     = '0;
                state_d = S_MAC;
            end
            S_MAC: begin
                if (k_q == LAST_TAP) begin
                    state_d = S_DRAIN;
                    drain_d = '0;
                    wrPtr_d = (wrPtr_q == LAST_TAP) ? '0 : wrPtr_q + 1'b1;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                if (outValid_q && seq_if.outReady) begin
                    state_d = (B2B && seq_if.inValid) ? S_WRITE : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state
        inReady_d     = (state_d == S_IDLE);
        sampWe_d      = (state_d == S_WRITE);
        outValid_d    = (state_d == S_DONE);
        accEn_d       = 1'b0;
        accClr_d      = 1'b0;
        sampAddress_d = sampAddress_q;
        coefAddress_d = coefAddress_q;

        unique case (state_d)
            S_IDLE, S_WRITE: begin
                sampAddress_d = wrPtr_d;
            end
            S_MAC: begin
                sampAddress_d = rd_addr(wrPtr_d, k_d);
                coefAddress_d = k_d;
                accEn_d       = 1'b1;
                accClr_d      = (k_d == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            wrPtr_q       <= '0;
            k_q           <= '0;
            drain_q       <= '0;
            inReady_q     <= 1'b0;
            sampWe_q      <= 1'b0;
            sampAddress_q <= '0;
            coefAddress_q <= '0;
            accClr_q      <= 1'b0;
            accEn_q       <= 1'b0;
            outValid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wrPtr_q       <= wrPtr_d;
            k_q           <= k_d;
            drain_q       <= drain_d;
            inReady_q     <= inReady_d;
            sampWe_q      <= sampWe_d;
            sampAddress_q <= sampAddress_d;
            coefAddress_q <= coefAddress_d;
            accClr_q      <= accClr_d;
            accEn_q       <= accEn_d;
            outValid_q    <= outValid_d;
        end
    end

    // In back-to-back mode inReady follows outReady while a result is pending,
    // which is the only combinational path through this block.
    assign seq_if.inReady     = inReady_q | (B2B & (state_q == S_DONE) & seq_if.outReady);
    assign seq_if.sampWe      = sampWe_q;
    assign seq_if.sampAddress = sampAddress_q;
    assign seq_if.coefAddress = coefAddress_q;
    assign seq_if.accClr      = accClr_q;
    assign seq_if.accEn       = accEn_q;
    assign seq_if.outValid    = outValid_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_tap_sequencer.sv
`default_nettype none
// ============================================================================
// tb_fir_tap_sequencer : checks a TAPS=8 and a TAPS=5 sequencer against a
// phase-based reference model under directed and random handshakes.  Rev 1.0
// ============================================================================
module tb_fir_tap_sequencer;

    localparam int ADDR_W   = 3;
    localparam int PIPE_LAT = 1;
`ifdef FIR_TAP_SEQ_B2B_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_tap_sequencer_if #(.ADDR_W(ADDR_W)) if0 ();
    fir_tap_sequencer_if #(.ADDR_W(ADDR_W)) if1 ();

    fir_tap_sequencer #(.TAPS(8), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)) u_dut0 (
        .clk    (clk),
        .rst    (rst),
        .seq_if (if0.master)
    );

    fir_tap_sequencer #(.TAPS(5), .ADDR_W(ADDR_W), .PIPE_LAT(PIPE_LAT)) u_dut1 (
        .clk    (clk),
        .rst    (rst),
        .seq_if (if1.master)
    );

    logic [1:0] inV  = 2'b00;
    logic [1:0] outR = 2'b00;
    assign if0.inValid  = inV[0];
    assign if0.outReady = outR[0];
    assign if1.inValid  = inV[1];
    assign if1.outReady = outR[1];

    logic [1:0]        o_ir, o_we, o_clr, o_en, o_ov;
    logic [ADDR_W-1:0] o_sa [2];
    logic [ADDR_W-1:0] o_ca [2];
    assign o_ir  = {if1.inReady,  if0.inReady};
    assign o_we  = {if1.sampWe,   if0.sampWe};
    assign o_clr = {if1.accClr,   if0.accClr};
    assign o_en  = {if1.accEn,    if0.accEn};
    assign o_ov  = {if1.outValid, if0.outValid};
    assign o_sa[0] = if0.sampAddress;
    assign o_sa[1] = if1.sampAddress;
    assign o_ca[0] = if0.coefAddress;
    assign o_ca[1] = if1.coefAddress;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: ph = cycles since the accepting handshake (0 = idle).
    // ph 1 = write, 2..T+1 = MAC tap ph-2, then drain, then result pending.
    int taps [2] = '{8, 5};
    int ph   [2];
    int wr   [2];
    int base [2];
    bit once [2];
    bit rstOut [2];
    int cyc    = 0;
    int lastWe = -1;
    bit dirWin = 1'b0;

    task automatic compare_dut(input int d);
        int t, k;
        int e_ir, e_we, e_sa, e_ca, e_clr, e_en, e_ov;
        t = taps[d];
        e_ir = 0; e_we = 0; e_clr = 0; e_en = 0; e_ov = 0;
        e_sa = wr[d];
        e_ca = once[d] ? t - 1 : 0;
        if (rstOut[d]) begin
            e_sa = 0;
            e_ca = 0;
        end else if (ph[d] == 0) begin
            e_ir = 1;
        end else if (ph[d] == 1) begin
            e_we = 1;
            e_sa = base[d];
        end else if (ph[d] <= t + 1) begin
            k     = ph[d] - 2;
            e_sa  = (base[d] - k + t) % t;
            e_ca  = k;
            e_en  = 1;
            e_clr = (k == 0) ? 1 : 0;
        end else begin
            e_sa = (base[d] + 1) % t;
            e_ca = t - 1;
            if (ph[d] >= t + 2 + PIPE_LAT) begin
                e_ov = 1;
                e_ir = B2B ? int'(outR[d]) : 0;
            end
        end
        check($sformatf("d%0d.inReady", d),     int'(o_ir[d]),  e_ir);
        check($sformatf("d%0d.sampWe", d),      int'(o_we[d]),  e_we);
        check($sformatf("d%0d.sampAddress", d), int'(o_sa[d]),  e_sa);
        check($sformatf("d%0d.coefAddress", d), int'(o_ca[d]),  e_ca);
        check($sformatf("d%0d.accClr", d),      int'(o_clr[d]), e_clr);
        check($sformatf("d%0d.accEn", d),       int'(o_en[d]),  e_en);
        check($sformatf("d%0d.outValid", d),    int'(o_ov[d]),  e_ov);
        if (d == 0 && dirWin && o_we[0]) begin
            if (lastWe >= 0) check("d0.wePeriod", cyc - lastWe, B2B ? 11 : 12);
            lastWe = cyc;
        end
    endtask

    task automatic update_dut(input int d, input bit v, input bit r, input bit rs);
        int t;
        bit hs;
        t  = taps[d];
        hs = 1'b0;
        if (!rs) begin
            ph[d] = 0; wr[d] = 0; base[d] = 0; once[d] = 1'b0; rstOut[d] = 1'b1;
        end else if (rstOut[d]) begin
            rstOut[d] = 1'b0;
        end else if (ph[d] == 0) begin
            hs = v;
        end else if (ph[d] >= t + 2 + PIPE_LAT) begin
            if (r) begin
                if (B2B && v) hs = 1'b1;
                else          ph[d] = 0;
            end
        end else begin
            if (ph[d] == t + 1) once[d] = 1'b1;
            ph[d]++;
        end
        if (hs) begin
            base[d] = wr[d];
            wr[d]   = (wr[d] + 1) % t;
            ph[d]   = 1;
        end
    endtask

    // One clock: check outputs, apply inputs for the next edge, advance model.
    task automatic step(input bit v0, input bit r0, input bit v1, input bit r1, input bit rs);
        compare_dut(0);
        compare_dut(1);
        inV  = {v1, v0};
        outR = {r1, r0};
        if (!rs && rst) begin
            rst = 1'b0;
            #1;
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d.asyncAccEn", d),    int'(o_en[d]), 0);
                check($sformatf("d%0d.asyncOutValid", d), int'(o_ov[d]), 0);
                check($sformatf("d%0d.asyncSampWe", d),   int'(o_we[d]), 0);
                check($sformatf("d%0d.asyncInReady", d),  int'(o_ir[d]), 0);
            end
        end else begin
            rst = rs;
        end
        update_dut(0, v0, r0, rs);
        update_dut(1, v1, r1, rs);
        cyc++;
        @(negedge clk);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++) begin
            step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)), 1'b1);
        end
    endtask

    initial begin
        int g;
        for (int d = 0; d < 2; d++) begin
            ph[d] = 0; wr[d] = 0; base[d] = 0; once[d] = 1'b0; rstOut[d] = 1'b1;
        end
        #2 rst = 1'b0;
        @(negedge clk);

        // Reset held 3 cycles with traffic offered, then continuous streaming
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        dirWin = 1'b1;
        repeat (40) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        dirWin = 1'b0;

        // Backpressure: park the TAPS=8 result in DONE with inValid held high
        g = 0;
        while (ph[0] < 8 + 2 + PIPE_LAT && g < 60) begin
            step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
            g++;
        end
        check("wait_done", (ph[0] >= 8 + 2 + PIPE_LAT) ? 1 : 0, 1);
        repeat (20) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        repeat (15) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        rand_steps(1500);

        // Reset while the TAPS=8 instance is at MAC tap 3
        g = 0;
        while (ph[0] != 5 && g < 100) begin
            step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
            g++;
        end
        check("wait_mac", ph[0], 5);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);

        rand_steps(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
